// File: rtl/note_recorder.sv
// note_recorder: records keyboard note messages with millisecond delta timestamps
// and replays them to the player with the original timing.
//
// In idle, messages pass straight through. In record, each message is still
// passed through and is also stored as {delta_ms, msg} in on-chip RAM. In play,
// the block itself is the message source.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   clk_msg_in   keyboard message strobe (message valid on 0->1)
//   msg_in       [7] note-on flag, [6:0] note id
//   cmd_rec      pulse: start recording
//   cmd_play     pulse: start playback
//   cmd_stop     pulse: stop recording or playback
//   clk_msg_out  message strobe to player, high STROBE_LEN cycles per message
//   msg_out      message to player
//   recording    high while recording
//   playing      high in any playback state
//   count        number of stored events
//   full         high when count == DEPTH
//
// Build option: define NOTE_RECORDER_LOOP_EN to repeat playback until cmd_stop.

module note_recorder #(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned STROBE_LEN = 4,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_msg_in,
  input  logic [7:0]    msg_in,
  input  logic          cmd_rec,
  input  logic          cmd_play,
  input  logic          cmd_stop,
  output logic          clk_msg_out,
  output logic [7:0]    msg_out,
  output logic          recording,
  output logic          playing,
  output logic [AW:0]   count,
  output logic          full
);

  localparam int unsigned PrescDiv = CLK_FREQ / 1000;
  localparam int unsigned PrescW   = $clog2(PrescDiv);
  localparam int unsigned StrW     = $clog2(STROBE_LEN + 1);

  localparam logic [PrescW-1:0] PrescMax = PrescW'(PrescDiv - 1);
  localparam logic [PrescW-1:0] PrescOne = PrescW'(1);
  localparam logic [StrW-1:0]   StrLen   = StrW'(STROBE_LEN);
  localparam logic [StrW-1:0]   StrOne   = StrW'(1);
  localparam logic [AW:0]       CntOne   = (AW + 1)'(1);
  localparam logic [AW:0]       CntDepth = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StRec, StPFetch, StPWait, StPEmit} state_e;

  state_e            state_q, state_d;
  logic              clk_msg_in_q;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [15:0]       delta_q, delta_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]        msg_out_q, msg_out_d;
  logic              clk_out_q, clk_out_d;
  logic [StrW-1:0]   strobe_q, strobe_d;

  // Event RAM: {delta_ms[15:0], msg[7:0]}; contents are not reset.
  logic [23:0]       mem [DEPTH];
  logic [23:0]       rd_data_q;
  logic              mem_we, mem_re;

  logic              edge_in, tick, play_st, last_entry;
  logic              emit;
  logic [7:0]        emit_val;

  assign edge_in    = clk_msg_in & ~clk_msg_in_q;
  assign tick       = (presc_q == PrescMax);
  assign play_st    = (state_q == StPFetch) || (state_q == StPWait) || (state_q == StPEmit);
  assign last_entry = (({1'b0, rd_ptr_q} + CntOne) == count_q);

  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + PrescOne;
    delta_d  = (tick && delta_q != 16'hFFFF) ? delta_q + 16'd1 : delta_q;
    count_d  = count_q;
    full_d   = full_q;
    rd_ptr_d = rd_ptr_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    emit     = 1'b0;
    emit_val = msg_in;

    case (state_q)
      StIdle: begin
        if (edge_in) emit = 1'b1;
        if (cmd_stop) begin
          // Stop outranks rec/play; nothing to stop in idle.
        end else if (cmd_rec) begin
          count_d = '0;
          full_d  = 1'b0;
          presc_d = '0;
          delta_d = '0;
          state_d = StRec;
        end else if (cmd_play && count_q != '0) begin
          rd_ptr_d = '0;
          state_d  = StPFetch;
        end
      end
      StRec: begin
        if (edge_in) begin
          emit    = 1'b1;
          mem_we  = 1'b1;
          count_d = count_q + CntOne;
          presc_d = '0;
          delta_d = '0;
          if (count_q + CntOne == CntDepth) begin
            full_d  = 1'b1;
            state_d = StIdle;
          end
        end
        if (cmd_stop) state_d = StIdle;
      end
      StPFetch: begin
        mem_re  = 1'b1;
        presc_d = '0;
        delta_d = '0;
        state_d = StPWait;
      end
      StPWait: begin
        if (delta_q == rd_data_q[23:8]) state_d = StPEmit;
      end
      StPEmit: begin
        emit     = 1'b1;
        emit_val = rd_data_q[7:0];
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (last_entry) begin
`ifdef NOTE_RECORDER_LOOP_EN
          rd_ptr_d = '0;
          state_d  = StPFetch;
`else
          state_d  = StIdle;
`endif
        end else begin
          state_d = StPFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stopping playback sends a release so no note is left sounding.
    if (play_st && cmd_stop) begin
      emit     = 1'b1;
      emit_val = 8'h00;
      state_d  = StIdle;
    end
  end

  // Shared emitter: msg updates with strobe low, then strobe high STROBE_LEN cycles.
  // A new emission restarts the sequence, giving a one-cycle low gap.
  always_comb begin
    msg_out_d = msg_out_q;
    clk_out_d = 1'b0;
    strobe_d  = strobe_q;
    if (emit) begin
      msg_out_d = emit_val;
      strobe_d  = StrLen;
    end else if (strobe_q != '0) begin
      clk_out_d = 1'b1;
      strobe_d  = strobe_q - StrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      clk_msg_in_q <= 1'b0;
      presc_q      <= '0;
      delta_q      <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      rd_ptr_q     <= '0;
      msg_out_q    <= 8'h00;
      clk_out_q    <= 1'b0;
      strobe_q     <= '0;
    end else begin
      state_q      <= state_d;
      clk_msg_in_q <= clk_msg_in;
      presc_q      <= presc_d;
      delta_q      <= delta_d;
      count_q      <= count_d;
      full_q       <= full_d;
      rd_ptr_q     <= rd_ptr_d;
      msg_out_q    <= msg_out_d;
      clk_out_q    <= clk_out_d;
      strobe_q     <= strobe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[AW-1:0]] <= {delta_q, msg_in};
    if (mem_re) rd_data_q <= mem[rd_ptr_q];
  end

  assign clk_msg_out = clk_out_q;
  assign msg_out     = msg_out_q;
  assign recording   = (state_q == StRec);
  assign playing     = play_st;
  assign count       = count_q;
  assign full        = full_q;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder (CLK_FREQ=12000 -> 12 cycles per ms, DEPTH=4).
module tb_note_recorder;

  logic       clk = 1'b0;
  logic       rst, clk_msg_in, cmd_rec, cmd_play, cmd_stop;
  logic [7:0] msg_in;
  logic       clk_msg_out, recording, playing, full;
  logic [7:0] msg_out;
  logic [2:0] count;

  note_recorder #(
    .CLK_FREQ  (12000),
    .DEPTH     (4),
    .STROBE_LEN(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_msg_in (clk_msg_in),
    .msg_in     (msg_in),
    .cmd_rec    (cmd_rec),
    .cmd_play   (cmd_play),
    .cmd_stop   (cmd_stop),
    .clk_msg_out(clk_msg_out),
    .msg_out    (msg_out),
    .recording  (recording),
    .playing    (playing),
    .count      (count),
    .full       (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int got, input int nom);
    check($sformatf("%s (got %0d cycles, nominal %0d +-3)", tag, got, nom),
          (got >= nom - 3 && got <= nom + 3), 1);
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] m, input int gap);
    step(gap);
    msg_in     = m;
    clk_msg_in = 1'b1;
    step(1);
    clk_msg_in = 1'b0;
    check($sformatf("pass_%0h", m), msg_out, m);
  endtask

  // Wait for a strobe rising edge; 'at' is the edge where msg_out took its value.
  task automatic wait_emit(input int limit, output int at);
    logic prev;
    prev = clk_msg_out;
    at   = -1;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (clk_msg_out && !prev) begin
        at = cyc - 1;
        break;
      end
      prev = clk_msg_out;
    end
    if (at < 0) begin
      check("emit_timeout", 0, 1);
      at = cyc;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         f, t1, t2, t3, t, hi;
    logic [7:0] last_out;
    logic [7:0] exp4 [4];
    exp4 = '{8'h11, 8'h12, 8'h13, 8'h14};

    rst = 1'b1; clk_msg_in = 1'b0; msg_in = 8'h00;
    cmd_rec = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
    step(3);
    check("rst_msg_out", msg_out, 8'h00);
    check("rst_clk_out", clk_msg_out, 0);
    check("rst_rec", recording, 0);
    check("rst_play", playing, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    rst = 1'b0;
    step(2);

    // Passthrough in idle.
    msg_in = 8'h85; clk_msg_in = 1'b1;
    step(1);
    check("pt_msg", msg_out, 8'h85);
    check("pt_strobe_low_at_emit", clk_msg_out, 0);
    clk_msg_in = 1'b0;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      hi += int'(clk_msg_out);
    end
    check("pt_strobe_len", hi, 4);
    check("pt_count", count, 0);

    // Record 0x81 @5ms, 0x00 @+7ms, 0x83 @+0ms.
    cmd_rec = 1'b1; step(1); cmd_rec = 1'b0;
    check("rec_on", recording, 1);
    send(8'h81, 66);
    send(8'h00, 90);
    send(8'h83, 5);
    step(3);
    cmd_stop = 1'b1; step(1); cmd_stop = 1'b0;
    check("rec_off", recording, 0);
    check("rec_count", count, 3);
    step(10);

    // Replay with timing.
    cmd_play = 1'b1; f = cyc + 1; step(1); cmd_play = 1'b0;
    check("play_on", playing, 1);
    wait_emit(200, t1);
    check("play_msg0", msg_out, 8'h81);
    check_time("play_first_latency", t1 - f, 60);
    wait_emit(200, t2);
    check("play_msg1", msg_out, 8'h00);
    check_time("play_gap1", t2 - t1, 84);
    wait_emit(50, t3);
    check("play_msg2", msg_out, 8'h83);
    check_time("play_gap2", t3 - t2, 0);
`ifndef NOTE_RECORDER_LOOP_EN
    check("play_done", playing, 0);
    last_out = 8'h83;
`else
    check("loop_still_playing", playing, 1);
    wait_emit(200, t); check("loop_msg0", msg_out, 8'h81);
    wait_emit(200, t); check("loop_msg1", msg_out, 8'h00);
    wait_emit(50, t);  check("loop_msg2", msg_out, 8'h83);
    cmd_stop = 1'b1; step(1); cmd_stop = 1'b0;
    check("loop_stopped", playing, 0);
    last_out = 8'h00;
`endif
    check("play_count_kept", count, 3);
    step(10);

    // Edge ignored during playback, then stop in P_WAIT.
    cmd_play = 1'b1; step(1); cmd_play = 1'b0;
    step(10);
    msg_in = 8'h55; clk_msg_in = 1'b1;
    step(1);
    clk_msg_in = 1'b0;
    check("play_no_pass_msg", msg_out, last_out);
    step(2);
    check("play_no_pass_strobe", clk_msg_out, 0);
    cmd_stop = 1'b1; step(1); cmd_stop = 1'b0;
    check("stop_msg", msg_out, 8'h00);
    check("stop_strobe_low", clk_msg_out, 0);
    check("stop_play_off", playing, 0);
    step(1);
    check("stop_strobe_high", clk_msg_out, 1);

    // Reset mid P_WAIT.
    cmd_play = 1'b1; step(1); cmd_play = 1'b0;
    step(10);
    check("pre_rst_play", playing, 1);
    rst = 1'b1; step(1); rst = 1'b0;
    check("mrst_msg", msg_out, 8'h00);
    check("mrst_clk", clk_msg_out, 0);
    check("mrst_play", playing, 0);
    check("mrst_rec", recording, 0);
    check("mrst_count", count, 0);
    check("mrst_full", full, 0);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      hi += int'(clk_msg_out);
    end
    check("mrst_no_emit", hi, 0);

    // Play with nothing recorded is ignored.
    cmd_play = 1'b1; step(1); cmd_play = 1'b0;
    check("empty_play", playing, 0);
    step(2);
    check("empty_play_later", playing, 0);

    // rec + play together -> record wins.
    cmd_rec = 1'b1; cmd_play = 1'b1; step(1); cmd_rec = 1'b0; cmd_play = 1'b0;
    check("prio_rec", recording, 1);
    check("prio_not_play", playing, 0);

    // Fill to DEPTH.
    send(8'h11, 3);
    send(8'h12, 3);
    send(8'h13, 3);
    check("fill_count3", count, 3);
    check("fill_not_full", full, 0);
    check("fill_rec_on", recording, 1);
    send(8'h14, 3);
    check("full_flag", full, 1);
    check("full_rec_off", recording, 0);
    check("full_count", count, 4);
    send(8'h15, 3);
    check("full_count_kept", count, 4);
    step(8);

    // Replay the full buffer.
    cmd_play = 1'b1; step(1); cmd_play = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_emit(50, t);
      check($sformatf("full_play_msg%0d", i), msg_out, exp4[i]);
    end
`ifndef NOTE_RECORDER_LOOP_EN
    check("full_play_done", playing, 0);
`else
    for (int i = 0; i < 4; i++) begin
      wait_emit(50, t);
      check($sformatf("full_loop_msg%0d", i), msg_out, exp4[i]);
    end
    cmd_stop = 1'b1; step(1); cmd_stop = 1'b0;
    check("full_loop_stop", playing, 0);
`endif
    check("full_play_count", count, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
